pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
Central stall/flush controller for the 5-stage pipeline. It drives the enable and NOP-insert controls of the PC, the fetch/decode pipeline register and the decode/execute register. It also freezes the whole pipe on data-memory stalls. It arbitrates between load-use hazards, taken branches, instruction- and data-memory stalls and HALT, and runs a drain/halt state machine plus a stall-cycle counter.

Parameters:
REG_AW, 3, register-specifier width
DRAIN_CYCLES, 2, cycles after HALT leaves EX before the pipe is declared halted (MEM, WB)
CNT_W, 16, width of stall-cycle performance counter

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
id_rs  in  REG_AW  source reg 1 of instruction in decode
id_rt  in  REG_AW  source reg 2 of instruction in decode
id_rs_used  in  1  decode instruction reads id_rs
id_rt_used  in  1  decode instruction reads id_rt
ex_memread  in  1  instruction in EX is a load
ex_rd  in  REG_AW  destination of instruction in EX
br_taken_ex  in  1  branch/jump resolved taken in EX (redirect this cycle)
halt_ex  in  1  HALT instruction is in EX
imem_stall  in  1  instruction memory not ready this cycle
dmem_stall  in  1  data memory not ready this cycle
pc_en  out  1  PC register load enable
ifid_en  out  1  fetch/decode register enable
ifid_flush  out  1  load NOP into fetch/decode register (valid only with ifid_en=1)
idex_en  out  1  decode/execute register enable
idex_bubble  out  1  load NOP into decode/execute register
exmem_en  out  1  execute/memory register enable
memwb_bubble  out  1  load NOP into memory/writeback register
halted  out  1  pipeline fully drained after HALT (registered)
stall_cycles  out  CNT_W  count of cycles with pc_en=0 while in RUN (registered)

Behaviour:
- States: RUN, DRAIN, HALTED. Reset state RUN; drain counter 0; halted 0; stall_cycles 0.
- While rst=1, all outputs are 0: enables, flush and bubble.
- Controls are combinational from inputs and state, with zero latency. They act at the next rising edge.
- load_use = ex_memread & ((id_rs_used & id_rs==ex_rd) | (id_rt_used & id_rt==ex_rd)).
- RUN priority, highest first:
  1. dmem_stall: pc_en=ifid_en=idex_en=exmem_en=0; memwb_bubble=1; all other outputs 0. A branch or HALT in EX is held, not acted on.
  2. halt_ex: pc_en=0, ifid_en=1, ifid_flush=1, idex_en=1, idex_bubble=1, exmem_en=1. Next state DRAIN, counter loads DRAIN_CYCLES.
  3. br_taken_ex: pc_en=1 (PC takes target), ifid_en=1, ifid_flush=1, idex_en=1, idex_bubble=1, exmem_en=1. This 2-instruction squash overrides load_use and imem_stall.
  4. load_use: pc_en=0, ifid_en=0, idex_en=1, idex_bubble=1, exmem_en=1. Exactly one bubble per hazard occurrence.
  5. imem_stall: pc_en=0, ifid_en=1, ifid_flush=1, idex_en=1, exmem_en=1. A NOP enters decode.
  6. otherwise: pc_en=ifid_en=idex_en=exmem_en=1; flush and bubbles 0.
- DRAIN state:
  - pc_en=0; ifid_en=1 with ifid_flush=1; idex_en=1 with idex_bubble=1; exmem_en=1.
  - Branch, load_use and imem inputs are ignored.
  - dmem_stall freezes as in case 1 and does not decrement the counter.
  - Counter decrements each unstalled cycle. Transition to HALTED on the edge where the counter is 1.
- HALTED: all enables 0, bubbles 0; halted=1 from the first HALTED cycle. Sticky until rst.
- stall_cycles:
  - Increments on each RUN-state edge with pc_en=0 and rst=0. DRAIN and HALTED cycles are not counted.
  - Saturates at all-ones; no wrap.
- Reset asserted mid-DRAIN or in HALTED immediately returns to RUN on deassertion with counters cleared.
- Register specifier 0 is a real register; no r0 exemption in the compare.

Decomposition:
- Package pipe_ctrl_pkg holds:
  - state enum (RUN, DRAIN, HALTED)
  - REG_AW default
  - NOP encoding constant shared with the pipeline registers
- Natural sub-module: load_use_detect. It is purely combinational and computes load_use from the id_*/ex_* ports. The FSM, priority encoder and counter stay in the top.

Test Plan:
- Reset then idle inputs -> cycle 1: pc_en=ifid_en=idex_en=exmem_en=1, halted=0, stall_cycles=0.
- ex_memread=1, ex_rd=3, id_rs=3, id_rs_used=1 for one cycle -> pc_en=0, ifid_en=0, idex_bubble=1; next cycle normal; stall_cycles=1.
- br_taken_ex=1 together with load_use and imem_stall -> pc_en=1, ifid_flush=1, idex_bubble=1; stall_cycles unchanged.
- dmem_stall=1 for 3 cycles with br_taken_ex=1 -> all enables 0, memwb_bubble=1 for 3 cycles; on cycle 4 the branch squash is applied.
- halt_ex=1, then dmem_stall=1 on the first DRAIN cycle -> HALTED reached 3 edges after halt (not 2); halted=1 and all enables 0 until rst.
- Force 2^CNT_W+5 imem_stall cycles -> stall_cycles saturates at 0xFFFF. rst pulse mid-DRAIN -> state RUN, counters 0.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush controller and the
// pipeline registers it steers.
package pipe_ctrl_pkg;

  localparam int REG_AW_DEF = 3;

  // Instruction word loaded into a pipeline register when it is flushed or bubbled.
  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_DRAIN,
    ST_HALTED
  } state_e;

endpackage

// File: rtl/load_use_detect.sv
// Flags a decode-stage read of the register that a load currently in EX will write.
module load_use_detect
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEF
) (
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_rs_used,
  input  logic              id_rt_used,
  input  logic              ex_memread,
  input  logic [REG_AW-1:0] ex_rd,
  output logic              load_use
);

  logic rs_hit;
  logic rt_hit;

  // Register 0 is an ordinary register here, so it takes part in the compare.
  always_comb begin
    rs_hit   = id_rs_used && (id_rs == ex_rd);
    rt_hit   = id_rt_used && (id_rt == ex_rd);
    load_use = ex_memread && (rs_hit || rt_hit);
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipe: priority arbitration of hazards,
// a RUN/DRAIN/HALTED state machine and a saturating stall-cycle counter.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_AW       = REG_AW_DEF,
  parameter int DRAIN_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_rs_used,
  input  logic              id_rt_used,
  input  logic              ex_memread,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              br_taken_ex,
  input  logic              halt_ex,
  input  logic              imem_stall,
  input  logic              dmem_stall,
  output logic              pc_en,
  output logic              ifid_en,
  output logic              ifid_flush,
  output logic              idex_en,
  output logic              idex_bubble,
  output logic              exmem_en,
  output logic              memwb_bubble,
  output logic              halted,
  output logic [CNT_W-1:0]  stall_cycles
);

  localparam int DCW = (DRAIN_CYCLES < 1) ? 1 : $clog2(DRAIN_CYCLES + 1);

  state_e           state_q, state_d;
  logic [DCW-1:0]   drain_cnt_q, drain_cnt_d;
  logic             halted_q, halted_d;
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;

  logic load_use;
  logic pc_en_c, ifid_en_c, ifid_flush_c, idex_en_c, idex_bubble_c, exmem_en_c, memwb_bubble_c;

  load_use_detect #(
    .REG_AW(REG_AW)
  ) u_load_use_detect (
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .id_rs_used (id_rs_used),
    .id_rt_used (id_rt_used),
    .ex_memread (ex_memread),
    .ex_rd      (ex_rd),
    .load_use   (load_use)
  );

  always_comb begin
    pc_en_c        = 1'b0;
    ifid_en_c      = 1'b0;
    ifid_flush_c   = 1'b0;
    idex_en_c      = 1'b0;
    idex_bubble_c  = 1'b0;
    exmem_en_c     = 1'b0;
    memwb_bubble_c = 1'b0;
    state_d        = state_q;
    drain_cnt_d    = drain_cnt_q;
    halted_d       = halted_q;
    stall_cycles_d = stall_cycles_q;

    case (state_q)
      ST_RUN: begin
        if (dmem_stall) begin
          // Whole pipe frozen; a branch or HALT sitting in EX is simply held.
          memwb_bubble_c = 1'b1;
        end else if (halt_ex) begin
          ifid_en_c     = 1'b1;
          ifid_flush_c  = 1'b1;
          idex_en_c     = 1'b1;
          idex_bubble_c = 1'b1;
          exmem_en_c    = 1'b1;
          state_d       = ST_DRAIN;
          drain_cnt_d   = DCW'(DRAIN_CYCLES);
        end else if (br_taken_ex) begin
          // Squashing the two younger instructions also clears any load-use or
          // fetch-stall condition they carried.
          pc_en_c       = 1'b1;
          ifid_en_c     = 1'b1;
          ifid_flush_c  = 1'b1;
          idex_en_c     = 1'b1;
          idex_bubble_c = 1'b1;
          exmem_en_c    = 1'b1;
        end else if (load_use) begin
          idex_en_c     = 1'b1;
          idex_bubble_c = 1'b1;
          exmem_en_c    = 1'b1;
        end else if (imem_stall) begin
          ifid_en_c    = 1'b1;
          ifid_flush_c = 1'b1;
          idex_en_c    = 1'b1;
          exmem_en_c   = 1'b1;
        end else begin
          pc_en_c    = 1'b1;
          ifid_en_c  = 1'b1;
          idex_en_c  = 1'b1;
          exmem_en_c = 1'b1;
        end

        if (!pc_en_c && (stall_cycles_q != {CNT_W{1'b1}})) begin
          stall_cycles_d = stall_cycles_q + CNT_W'(1);
        end
      end

      ST_DRAIN: begin
        if (dmem_stall) begin
          memwb_bubble_c = 1'b1;
        end else begin
          ifid_en_c     = 1'b1;
          ifid_flush_c  = 1'b1;
          idex_en_c     = 1'b1;
          idex_bubble_c = 1'b1;
          exmem_en_c    = 1'b1;
          if (drain_cnt_q <= DCW'(1)) begin
            state_d     = ST_HALTED;
            drain_cnt_d = '0;
            halted_d    = 1'b1;
          end else begin
            drain_cnt_d = drain_cnt_q - DCW'(1);
          end
        end
      end

      ST_HALTED: begin
        halted_d = 1'b1;
      end

      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_RUN;
      drain_cnt_q    <= '0;
      halted_q       <= 1'b0;
      stall_cycles_q <= '0;
    end else begin
      state_q        <= state_d;
      drain_cnt_q    <= drain_cnt_d;
      halted_q       <= halted_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  // Controls are forced inactive for as long as reset is held.
  assign pc_en        = pc_en_c        & ~rst;
  assign ifid_en      = ifid_en_c      & ~rst;
  assign ifid_flush   = ifid_flush_c   & ~rst;
  assign idex_en      = idex_en_c      & ~rst;
  assign idex_bubble  = idex_bubble_c  & ~rst;
  assign exmem_en     = exmem_en_c     & ~rst;
  assign memwb_bubble = memwb_bubble_c & ~rst;
  assign halted       = halted_q;
  assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed cycles push hand-computed
// expectations, a negedge monitor pops and compares them.
module tb_pipe_hazard_ctrl;

  logic        clk;
  logic        rst;
  logic [2:0]  id_rs, id_rt, ex_rd;
  logic        id_rs_used, id_rt_used, ex_memread;
  logic        br_taken_ex, halt_ex, imem_stall, dmem_stall;
  logic        pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, exmem_en, memwb_bubble;
  logic        halted;
  logic [15:0] stall_cycles;

  pipe_hazard_ctrl #(
    .REG_AW(3),
    .DRAIN_CYCLES(2),
    .CNT_W(16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_rs_used   (id_rs_used),
    .id_rt_used   (id_rt_used),
    .ex_memread   (ex_memread),
    .ex_rd        (ex_rd),
    .br_taken_ex  (br_taken_ex),
    .halt_ex      (halt_ex),
    .imem_stall   (imem_stall),
    .dmem_stall   (dmem_stall),
    .pc_en        (pc_en),
    .ifid_en      (ifid_en),
    .ifid_flush   (ifid_flush),
    .idex_en      (idex_en),
    .idex_bubble  (idex_bubble),
    .exmem_en     (exmem_en),
    .memwb_bubble (memwb_bubble),
    .halted       (halted),
    .stall_cycles (stall_cycles)
  );

  // Control vector order: pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, exmem_en, memwb_bubble
  localparam logic [6:0] C_OFF  = 7'b0000000;
  localparam logic [6:0] C_NORM = 7'b1101010;
  localparam logic [6:0] C_LU   = 7'b0001110;
  localparam logic [6:0] C_BR   = 7'b1111110;
  localparam logic [6:0] C_IMEM = 7'b0111010;
  localparam logic [6:0] C_DMEM = 7'b0000001;
  localparam logic [6:0] C_DRN  = 7'b0111110;

  typedef struct {
    logic [6:0]  ctl;
    logic        h;
    logic [15:0] s;
    string       nm;
  } exp_t;

  exp_t exp_q[$];
  int   chk_cnt  = 0;
  int   pass_cnt = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      exp_t e;
      logic [23:0] got;
      logic [23:0] want;
      e    = exp_q.pop_front();
      got  = {pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, exmem_en, memwb_bubble, halted, stall_cycles};
      want = {e.ctl, e.h, e.s};
      chk_cnt++;
      if (got === want) pass_cnt++;
      else $display("FAIL %s: got ctl=%b halted=%b stall=%0d, want ctl=%b halted=%b stall=%0d",
                    e.nm, got[23:17], got[16], got[15:0], e.ctl, e.h, e.s);
    end
  end

  task automatic drive(input logic r, input logic [2:0] rs, input logic rsu, input logic [2:0] rt,
                       input logic rtu, input logic mr, input logic [2:0] rd, input logic br,
                       input logic hl, input logic im, input logic dm);
    @(posedge clk);
    #1;
    rst = r; id_rs = rs; id_rs_used = rsu; id_rt = rt; id_rt_used = rtu;
    ex_memread = mr; ex_rd = rd; br_taken_ex = br; halt_ex = hl; imem_stall = im; dmem_stall = dm;
  endtask

  task automatic expect_now(input logic [6:0] c, input logic h, input logic [15:0] s, input string nm);
    exp_t e;
    e.ctl = c; e.h = h; e.s = s; e.nm = nm;
    exp_q.push_back(e);
  endtask

  // Idle: no load in EX, no branch/halt/stalls.
  task automatic cyc_idle(input logic r, input logic [6:0] c, input logic h, input logic [15:0] s, input string nm);
    drive(r, 3'd1, 1'b1, 3'd2, 1'b1, 1'b0, 3'd7, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_now(c, h, s, nm);
  endtask

  initial begin
    rst = 1'b0;
    id_rs = '0; id_rt = '0; ex_rd = '0;
    id_rs_used = 1'b0; id_rt_used = 1'b0; ex_memread = 1'b0;
    br_taken_ex = 1'b0; halt_ex = 1'b0; imem_stall = 1'b0; dmem_stall = 1'b0;
    #2 rst = 1'b1;

    cyc_idle(1'b1, C_OFF, 1'b0, 16'd0, "reset_idle");
    drive(1'b1, 3'd1, 1'b0, 3'd2, 1'b0, 1'b0, 3'd7, 1'b1, 1'b1, 1'b1, 1'b1);
    expect_now(C_OFF, 1'b0, 16'd0, "reset_all_req");

    cyc_idle(1'b0, C_NORM, 1'b0, 16'd0, "run_first");
    drive(1'b0, 3'd3, 1'b1, 3'd2, 1'b0, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_now(C_LU, 1'b0, 16'd0, "lu_rs");
    cyc_idle(1'b0, C_NORM, 1'b0, 16'd1, "after_lu");
    drive(1'b0, 3'd3, 1'b0, 3'd5, 1'b1, 1'b1, 3'd5, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_now(C_LU, 1'b0, 16'd1, "lu_rt");
    drive(1'b0, 3'd3, 1'b1, 3'd5, 1'b1, 1'b1, 3'd4, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_now(C_NORM, 1'b0, 16'd2, "load_no_match");
    drive(1'b0, 3'd3, 1'b1, 3'd5, 1'b1, 1'b0, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_now(C_NORM, 1'b0, 16'd2, "match_not_load");
    drive(1'b0, 3'd0, 1'b1, 3'd5, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_now(C_LU, 1'b0, 16'd2, "lu_r0");
    drive(1'b0, 3'd3, 1'b0, 3'd3, 1'b0, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_now(C_NORM, 1'b0, 16'd3, "match_unused");

    drive(1'b0, 3'd3, 1'b1, 3'd2, 1'b0, 1'b1, 3'd3, 1'b1, 1'b0, 1'b1, 1'b0);
    expect_now(C_BR, 1'b0, 16'd3, "br_over_lu_imem");
    drive(1'b0, 3'd1, 1'b0, 3'd2, 1'b0, 1'b0, 3'd7, 1'b0, 1'b0, 1'b1, 1'b0);
    expect_now(C_IMEM, 1'b0, 16'd3, "imem_stall");

    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 3'd1, 1'b0, 3'd2, 1'b0, 1'b0, 3'd7, 1'b1, 1'b0, 1'b0, 1'b1);
      expect_now(C_DMEM, 1'b0, 16'(4 + i), "dmem_hold_br");
    end
    drive(1'b0, 3'd1, 1'b0, 3'd2, 1'b0, 1'b0, 3'd7, 1'b1, 1'b0, 1'b0, 1'b0);
    expect_now(C_BR, 1'b0, 16'd7, "br_after_dmem");
    cyc_idle(1'b0, C_NORM, 1'b0, 16'd7, "idle_pre_halt");

    drive(1'b0, 3'd1, 1'b0, 3'd2, 1'b0, 1'b0, 3'd7, 1'b0, 1'b1, 1'b0, 1'b0);
    expect_now(C_DRN, 1'b0, 16'd7, "halt_ex");
    drive(1'b0, 3'd1, 1'b0, 3'd2, 1'b0, 1'b0, 3'd7, 1'b1, 1'b0, 1'b0, 1'b1);
    expect_now(C_DMEM, 1'b0, 16'd8, "drain_dmem");
    drive(1'b0, 3'd3, 1'b1, 3'd2, 1'b0, 1'b1, 3'd3, 1'b1, 1'b0, 1'b1, 1'b0);
    expect_now(C_DRN, 1'b0, 16'd8, "drain_ignore");
    cyc_idle(1'b0, C_DRN, 1'b0, 16'd8, "drain_last");
    cyc_idle(1'b0, C_OFF, 1'b1, 16'd8, "halted_1");
    drive(1'b0, 3'd1, 1'b0, 3'd2, 1'b0, 1'b0, 3'd7, 1'b1, 1'b1, 1'b1, 1'b0);
    expect_now(C_OFF, 1'b1, 16'd8, "halted_sticky");

    cyc_idle(1'b1, C_OFF, 1'b0, 16'd0, "rst_from_halted");
    cyc_idle(1'b0, C_NORM, 1'b0, 16'd0, "run_after_halted");
    drive(1'b0, 3'd3, 1'b1, 3'd2, 1'b0, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_now(C_LU, 1'b0, 16'd0, "lu_again");
    drive(1'b0, 3'd1, 1'b0, 3'd2, 1'b0, 1'b0, 3'd7, 1'b0, 1'b1, 1'b0, 1'b0);
    expect_now(C_DRN, 1'b0, 16'd1, "halt_again");
    cyc_idle(1'b0, C_DRN, 1'b0, 16'd2, "drain_again");
    cyc_idle(1'b1, C_OFF, 1'b0, 16'd0, "rst_mid_drain");
    cyc_idle(1'b0, C_NORM, 1'b0, 16'd0, "run_after_drain_rst");
    cyc_idle(1'b0, C_NORM, 1'b0, 16'd0, "run_stays");

    for (int i = 0; i < 65540; i++) begin
      drive(1'b0, 3'd1, 1'b0, 3'd2, 1'b0, 1'b0, 3'd7, 1'b0, 1'b0, 1'b1, 1'b0);
    end
    drive(1'b0, 3'd1, 1'b0, 3'd2, 1'b0, 1'b0, 3'd7, 1'b0, 1'b0, 1'b1, 1'b0);
    expect_now(C_IMEM, 1'b0, 16'hFFFF, "sat_reached");
    drive(1'b0, 3'd1, 1'b0, 3'd2, 1'b0, 1'b0, 3'd7, 1'b0, 1'b0, 1'b1, 1'b0);
    expect_now(C_IMEM, 1'b0, 16'hFFFF, "sat_hold");
    cyc_idle(1'b0, C_NORM, 1'b0, 16'hFFFF, "sat_idle");

    for (int i = 0; i < 4 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      chk_cnt++;
      $display("FAIL drain_queue: %0d entries left, want 0", exp_q.size());
    end
    #1;
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time %0t exceeded, want completion", $time);
    $fatal(1, "timeout");
  end

endmodule
